// File: rtl/cpu_ctrl_pkg.sv
// Shared control types for the LEGv8 pipeline: forwarding selects, the
// zero-register number and the in-flight producer record used by hazard logic.
package cpu_ctrl_pkg;

  localparam logic [4:0] XZR = 5'd31;

  // Scoreboard slot order: slot 0 is the youngest producer.
  localparam int SB_EX  = 0;
  localparam int SB_MEM = 1;
  localparam int SB_WB  = 2;
  localparam int SB_N   = 3;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
    logic       setflags;
  } sb_entry_t;

  // Youngest matching producer wins; no match reads the register file.
  function automatic fwd_sel_t youngest_src(input logic [SB_N-1:0] hit);
    fwd_sel_t sel;
    sel = FWD_REG;
    if (hit[SB_WB])  sel = FWD_WB;
    if (hit[SB_MEM]) sel = FWD_MEM;
    if (hit[SB_EX])  sel = FWD_EX;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one ID source operand against every scoreboard entry and returns
// a per-stage RAW match vector (bit 0 = EX, 1 = MEM, 2 = WB).
module hazard_match
  import cpu_ctrl_pkg::*;
(
  input  logic                 used,
  input  logic [4:0]           src,
  input  sb_entry_t [SB_N-1:0] sb,
  output logic [SB_N-1:0]      hit
);

  // XZR reads as zero, so it never depends on a producer.
  always_comb begin
    hit = '0;
    for (int i = 0; i < SB_N; i++) begin
      hit[i] = used & sb[i].valid & sb[i].regwrite &
               (sb[i].rd == src) & (src != XZR);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller beside the ID stage of the 5-stage LEGv8 pipe.
// Tracks EX/MEM/WB producers in a 3-entry scoreboard, raises stall, selects
// operand forwarding and squashes IF/ID on a resolved taken branch.
// Build option: define FORWARDING_EN to enable bypassing; otherwise every RAW
// hazard against an in-flight producer stalls and fwd_a/fwd_b stay 00.
module pipeline_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_setflags,
  input  logic             id_is_bcond,
  input  logic             id_brtaken,
  output logic             stall,
  output logic             ifid_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cycles
);

  sb_entry_t [SB_N-1:0] sb_q, sb_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SB_N-1:0]      hit_a, hit_b;
  logic                 load_use, flags_haz, raw_haz;
  fwd_sel_t             fwd_a_sel, fwd_b_sel;

  hazard_match u_match_rn (
    .used (id_uses_rn),
    .src  (id_rn),
    .sb   (sb_q),
    .hit  (hit_a)
  );

  hazard_match u_match_rm (
    .used (id_uses_rm),
    .src  (id_rm),
    .sb   (sb_q),
    .hit  (hit_b)
  );

  // Stall causes, forwarding selection and branch flush.
  always_comb begin
    load_use  = (hit_a[SB_EX] | hit_b[SB_EX]) & sb_q[SB_EX].memread;
    flags_haz = id_is_bcond & sb_q[SB_EX].valid & sb_q[SB_EX].setflags;
`ifdef FORWARDING_EN
    raw_haz   = 1'b0;
`else
    raw_haz   = (|hit_a) | (|hit_b);
`endif
    stall     = id_valid & (load_use | flags_haz | raw_haz);
    fwd_a_sel = FWD_REG;
    fwd_b_sel = FWD_REG;
`ifdef FORWARDING_EN
    if (!stall) begin
      fwd_a_sel = youngest_src(hit_a);
      fwd_b_sel = youngest_src(hit_b);
    end
`endif
    fwd_a      = fwd_a_sel;
    fwd_b      = fwd_b_sel;
    // An unresolved (stalled) branch must not squash the fetch stream yet.
    ifid_flush = id_valid & id_brtaken & ~stall;
  end

  // Next scoreboard: shift toward WB; a stall enters a bubble into EX.
  always_comb begin
    sb_d[SB_WB]           = sb_q[SB_MEM];
    sb_d[SB_MEM]          = sb_q[SB_EX];
    sb_d[SB_EX].valid     = id_valid & ~stall;
    sb_d[SB_EX].rd        = id_rd;
    sb_d[SB_EX].regwrite  = id_regwrite;
    sb_d[SB_EX].memread   = id_memread;
    sb_d[SB_EX].setflags  = id_setflags;
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_q  <= '0;
      cnt_q <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_cycles = cnt_q;

  // The WB entry's load/flag bits only travel along for uniformity.
  logic unused_sb;
  assign unused_sb = ^{sb_q[SB_WB].memread, sb_q[SB_WB].setflags,
                       sb_q[SB_MEM].memread, sb_q[SB_MEM].setflags};

endmodule
